onehot_reduce_ctrl: RTL and testbench
=====================================

ONEHOT_REDUCE_CTRL -- requirements
Module: onehot_reduce_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports in this order: clk, rst, start, data_in, ready, busy, done, err, result, index, iter_cnt.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to reduce data_in; sampled only when ready=1.
REQ-005 data_in  input  4  candidate mask captured on an accepted start.
REQ-006 ready  output  1  high only in IDLE.
REQ-007 busy  output  1  high in CHECK and STEP.
REQ-008 done  output  1  one-cycle pulse in DONE.
REQ-009 err  output  1  one-cycle pulse in ERR (zero mask).
REQ-010 result  output  4  final one-hot mask, registered and held until the next accepted start.
REQ-011 index  output  2  binary position of the result bit, held with result.
REQ-012 iter_cnt  output  3  number of reduction steps performed, held with result.

Function
REQ-013 States SHALL be IDLE, CHECK, STEP, DONE and ERR, with a registered state and registered outputs.
REQ-014 IDLE SHALL respond to start=1 as follows: on that edge, capture mask<=data_in, clear iter_cnt to 0, clear result and index to 0, and go to CHECK.
REQ-015 IDLE SHALL treat start=0 as a hold.
REQ-016 CHECK SHALL evaluate the mask combinationally as follows: mask==0 -> ERR; mask one-hot (exactly one of 1000/0100/0010/0001) -> DONE; otherwise -> STEP.
REQ-017 STEP SHALL clear the lowest set bit (mask <= mask AND (mask-1), 4-bit modulo), increment iter_cnt by 1, and return to CHECK.
REQ-018 iter_cnt SHALL NOT exceed 3, because a 4-bit mask needs at most 3 steps; no wrap is reachable.
REQ-019 On the edge entering DONE, result<=mask and index<=encode(mask); done=1 for exactly that cycle, then DONE -> IDLE unconditionally.
REQ-020 ERR SHALL assert err=1 for one cycle, leave result=0 and index=0, then go to IDLE.
REQ-021 start asserted outside IDLE SHALL be ignored, with no queueing and no restart.
REQ-022 Latency SHALL be measured from the start-accept edge to the cycle in which done is high: 2+2*(k-1) cycles for k set bits (k=1 -> 2, k=4 -> 8).
REQ-023 The reduction SHALL keep the highest set bit of data_in, so index SHALL equal the MSB position of data_in.
REQ-024 A start in the same cycle the block returns to IDLE SHALL NOT be accepted; it is accepted the following cycle only if still high.
REQ-025 done and err SHALL never be high in the same cycle.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, mask=0, result=0, index=0, iter_cnt=0, done=0, err=0 and busy=0, independent of clk.
REQ-027 After reset, ready SHALL be 1 (combinational from IDLE).
REQ-028 Reset asserted mid-operation (CHECK or STEP) SHALL abort without a done or err pulse.
REQ-029 The first start after rst deasserts SHALL be accepted on the next rising edge.

Configuration
REQ-030 When ONEHOT_ITER_COUNT_EN is defined, the iteration counter SHALL be implemented and iter_cnt SHALL behave per REQ-012/014/017.
REQ-031 When ONEHOT_ITER_COUNT_EN is undefined, no counter register SHALL exist and iter_cnt SHALL be tied to 3'b000; all other behaviour is unchanged.

Verification
REQ-032 Reset mid-run: data_in=4'b1111, start, assert rst during STEP -> all outputs 0, ready=1, no done/err pulse.
REQ-033 One-hot input: data_in=4'b0100 with start -> done high 2 cycles after accept, result=0100, index=2, iter_cnt=0.
REQ-034 Full mask: data_in=4'b1111 with start -> done at cycle 8, result=1000, index=3, iter_cnt=3 (0 without ONEHOT_ITER_COUNT_EN).
REQ-035 Zero mask: data_in=4'b0000 with start -> err pulse at cycle 2, done=0, result=0000, ready again at cycle 3.
REQ-036 Busy start ignored: data_in=4'b0110, start held high for 6 cycles -> a single done at cycle 4 with result=0100, index=2, iter_cnt=1, then a new run begins.

Source files
------------

// File: rtl/onehot_reduce_ctrl.sv
// rtl/onehot_reduce_ctrl.sv - reduces a 4-bit mask to its highest set bit by repeated lowest-bit clearing
//
// Purpose:
//   On an accepted start the 4-bit data_in is captured. The FSM then clears
//   the lowest set bit one step at a time until a single bit is left, and
//   reports that bit as a one-hot result together with its binary index.
//   A zero mask is reported with an err pulse instead.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       asynchronous, active-high reset
//   start     request to reduce data_in; only sampled while ready=1
//   data_in   candidate mask, captured on an accepted start
//   ready     high only in IDLE
//   busy      high in CHECK and STEP
//   done      one-cycle pulse when result/index become valid
//   err       one-cycle pulse for a zero mask
//   result    one-hot result, held until the next accepted start
//   index     binary position of the result bit, held with result
//   iter_cnt  reduction steps performed, held with result
//
// Configuration:
//   ONEHOT_ITER_COUNT_EN  when defined the step counter is built; otherwise
//                         iter_cnt is tied to zero and no counter exists.

module onehot_reduce_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] data_in,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] result,
  output logic [1:0] index,
  output logic [2:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_STEP  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] mask;
  logic       mask_zero;
  logic       mask_onehot;

  // m & (m-1) clears the lowest set bit; it is zero exactly when m has at
  // most one bit set.
  assign mask_zero   = (mask == 4'd0);
  assign mask_onehot = !mask_zero && ((mask & (mask - 4'd1)) == 4'd0);

  assign ready = (state == S_IDLE);

  function automatic logic [1:0] encode(input logic [3:0] m);
    logic [1:0] pos;
    pos = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) pos = 2'(i);
    end
    return pos;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      mask   <= 4'd0;
      result <= 4'd0;
      index  <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask   <= data_in;
            result <= 4'd0;
            index  <= 2'd0;
            busy   <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (mask_zero) begin
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= S_ERR;
          end else if (mask_onehot) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= mask;
            index  <= encode(mask);
            state  <= S_DONE;
          end else begin
            state <= S_STEP;
          end
        end
        S_STEP: begin
          mask  <= mask & (mask - 4'd1);
          state <= S_CHECK;
        end
        // start is ignored here, so a start coinciding with the return to
        // IDLE is only taken on the following edge.
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ONEHOT_ITER_COUNT_EN
  logic [2:0] iter_q;

  // At most three steps on a 4-bit mask, so the 3-bit counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q <= 3'd0;
    end else if (state == S_IDLE && start) begin
      iter_q <= 3'd0;
    end else if (state == S_STEP) begin
      iter_q <= iter_q + 3'd1;
    end
  end

  assign iter_cnt = iter_q;
`else
  assign iter_cnt = 3'b000;
`endif

endmodule

// File: tb/tb_onehot_reduce_ctrl.sv
// tb/tb_onehot_reduce_ctrl.sv - randomized self-checking bench for onehot_reduce_ctrl

module tb_onehot_reduce_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] data_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] result;
  logic [1:0] index;
  logic [2:0] iter_cnt;

  int checks;
  int errors;

  onehot_reduce_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .index    (index),
    .iter_cnt (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: reduction keeps the highest set bit; one step per
  // extra set bit, two cycles per step.
  task automatic model(input logic [3:0] d, output int lat, output logic [3:0] res,
                       output logic [1:0] idx, output logic [2:0] it, output logic is_err);
    int k;
    int msb;
    k   = 0;
    msb = 0;
    for (int i = 0; i < 4; i++) begin
      if (d[i]) begin
        k++;
        msb = i;
      end
    end
    is_err = (k == 0);
    lat    = (k == 0) ? 2 : 2 + 2 * (k - 1);
    res    = (k == 0) ? 4'd0 : 4'(1 << msb);
    idx    = (k == 0) ? 2'd0 : 2'(msb);
`ifdef ONEHOT_ITER_COUNT_EN
    it     = (k == 0) ? 3'd0 : 3'(k - 1);
`else
    it     = 3'd0;
`endif
  endtask

  // Called at a negedge with the DUT idle. noisy toggles start while busy;
  // hold keeps start high through the end of the run.
  task automatic run_txn(input logic [3:0] d, input bit noisy, input bit hold);
    int lat;
    logic [3:0] e_res;
    logic [1:0] e_idx;
    logic [2:0] e_it;
    logic e_err;
    model(d, lat, e_res, e_idx, e_it, e_err);
    check("ready_before", 32'(ready), 32'd1);
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      if (cyc < lat) begin
        check("busy_run", 32'(busy), 32'd1);
        check("ready_run", 32'(ready), 32'd0);
        check("early_pulse", 32'({done, err}), 32'd0);
        start   = hold ? 1'b1 : (noisy ? 1'($urandom_range(0, 1)) : 1'b0);
        data_in = 4'($urandom_range(0, 15));
      end else begin
        check("done", 32'(done), 32'(!e_err));
        check("err", 32'(err), 32'(e_err));
        check("busy_end", 32'(busy), 32'd0);
        check("result", 32'(result), 32'(e_res));
        check("index", 32'(index), 32'(e_idx));
        check("iter_cnt", 32'(iter_cnt), 32'(e_it));
        start = hold;
      end
    end
    @(negedge clk);
    check("ready_after", 32'(ready), 32'd1);
    check("pulse_after", 32'({done, err}), 32'd0);
    check("result_held", 32'(result), 32'(e_res));
    check("index_held", 32'(index), 32'(e_idx));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 4'd0;
    #12;
    check("rst_outs", 32'({busy, done, err, result, index, iter_cnt}), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases: one-hot, full mask, zero mask.
    run_txn(4'b0100, 1'b0, 1'b0);
    run_txn(4'b1111, 1'b1, 1'b0);
    run_txn(4'b0000, 1'b0, 1'b0);
    run_txn(4'b0001, 1'b0, 1'b0);

    // Start held high: one done, then an immediate new run that clears result.
    run_txn(4'b0110, 1'b0, 1'b1);
    @(negedge clk);
    check("rerun_busy", 32'(busy), 32'd1);
    check("rerun_result_clr", 32'(result), 32'd0);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("rerun_idle", 32'(ready), 32'd1);

    // Reset during STEP aborts without any pulse.
    data_in = 4'b1111;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outs", 32'({busy, done, err, result, index, iter_cnt}), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("midrst_pulse", 32'({done, err}), 32'd0);
    end
    rst = 1'b0;

    // First start after reset is taken on the next edge.
    run_txn(4'b1010, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_txn(4'($urandom_range(0, 15)), 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("idle_ready", 32'(ready), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
